// File: rtl/huff_freq_sorter.sv
// Huffman front end: captures freqcount entries and sorts them ascending by frequency, then symbol.
// The result is offered to the tree builder over a valid/ready handshake.
module huff_freq_sorter #(
  parameter int N_SYM  = 10,
  parameter int W      = 19,
  parameter int FREQ_W = 8,
  parameter int SYM_W  = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_coding,
  input  logic [W-1:0] data_in0,
  input  logic [W-1:0] data_in1,
  input  logic [W-1:0] data_in2,
  input  logic [W-1:0] data_in3,
  input  logic [W-1:0] data_in4,
  input  logic [W-1:0] data_in5,
  input  logic [W-1:0] data_in6,
  input  logic [W-1:0] data_in7,
  input  logic [W-1:0] data_in8,
  input  logic [W-1:0] data_in9,
  output logic         ack_coding,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sorted0,
  output logic [W-1:0] sorted1,
  output logic [W-1:0] sorted2,
  output logic [W-1:0] sorted3,
  output logic [W-1:0] sorted4,
  output logic [W-1:0] sorted5,
  output logic [W-1:0] sorted6,
  output logic [W-1:0] sorted7,
  output logic [W-1:0] sorted8,
  output logic [W-1:0] sorted9,
  output logic [3:0]   nz_count
);

  localparam int PW = $clog2(N_SYM);
  localparam int KW = FREQ_W + SYM_W;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    SORT,
    OUT
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  din [N_SYM];
  logic [W-1:0]  ent [N_SYM];
  logic [W-1:0]  swp [N_SYM];
  logic [PW-1:0] pass;
  logic [3:0]    nz_nx;
  logic          load;
  logic          do_pass;
  logic          last_pass;

  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;
  assign din[4] = data_in4;
  assign din[5] = data_in5;
  assign din[6] = data_in6;
  assign din[7] = data_in7;
  assign din[8] = data_in8;
  assign din[9] = data_in9;

  assign sorted0 = ent[0];
  assign sorted1 = ent[1];
  assign sorted2 = ent[2];
  assign sorted3 = ent[3];
  assign sorted4 = ent[4];
  assign sorted5 = ent[5];
  assign sorted6 = ent[6];
  assign sorted7 = ent[7];
  assign sorted8 = ent[8];
  assign sorted9 = ent[9];

  // Frequency is the major key, symbol breaks ties.
  function automatic logic [KW-1:0] key(
    input logic [W-1:0] e
  );
    return {e[FREQ_W-1:0], e[FREQ_W +: SYM_W]};
  endfunction

  assign last_pass = (pass == PW'(N_SYM - 1));

  always_comb begin
    nz_nx = '0;
    for (int i = 0; i < N_SYM; i++) begin
      nz_nx = nz_nx + 4'(din[i][FREQ_W-1:0] != '0);
    end
  end

  // Even passes pair (0,1),(2,3)..; odd passes pair (1,2),(3,4)..
  always_comb begin
    swp = ent;
    for (int i = 0; i < N_SYM - 1; i++) begin
      if (i[0] == pass[0] && key(ent[i]) > key(ent[i+1])) begin
        swp[i]   = ent[i+1];
        swp[i+1] = ent[i];
      end
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    do_pass  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_coding) begin
          load     = 1'b1;
          state_nx = ACK;
        end
      end
      ACK: begin
        do_pass  = 1'b1;
        state_nx = SORT;
      end
      SORT: begin
        do_pass = 1'b1;
        if (last_pass) state_nx = OUT;
      end
      OUT: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack_coding <= 1'b0;
      out_valid  <= 1'b0;
      nz_count   <= '0;
      pass       <= '0;
    end else begin
      state      <= state_nx;
      ack_coding <= load;
      out_valid  <= (state_nx == OUT);
      if (load) begin
        nz_count <= nz_nx;
        pass     <= '0;
      end else if (do_pass) begin
        pass <= pass + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SYM; i++) begin
        ent[i] <= '0;
      end
    end else if (load) begin
      ent <= din;
    end else if (do_pass) begin
      ent <= swp;
    end
  end

endmodule

// File: tb/tb_huff_freq_sorter.sv
// Directed bench for huff_freq_sorter.
// A stable-sort reference model predicts the list; literals pin selected cases.
module tb_huff_freq_sorter;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        ack;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] din [10];
  logic [18:0] srt [10];
  logic [3:0]  nz;

  logic [18:0] exp_s [10];
  int          exp_nz;
  bit          armed;
  int          total;
  int          bad;
  int          lat;
  int          acks;

  int id_syms [10]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int rev_syms [10] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
  int t1_syms [10]  = '{1, 4, 8, 5, 7, 2, 9, 0, 6, 3};
  int t1_freq [10]  = '{0, 0, 0, 1, 2, 3, 4, 5, 7, 9};
  int t1_in [10]    = '{5, 0, 3, 9, 0, 1, 7, 2, 0, 4};
  int t6_freq [10]  = '{6, 2, 6, 2, 0, 6, 2, 6, 2, 0};

  huff_freq_sorter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_coding (req),
    .data_in0   (din[0]),
    .data_in1   (din[1]),
    .data_in2   (din[2]),
    .data_in3   (din[3]),
    .data_in4   (din[4]),
    .data_in5   (din[5]),
    .data_in6   (din[6]),
    .data_in7   (din[7]),
    .data_in8   (din[8]),
    .data_in9   (din[9]),
    .ack_coding (ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sorted0    (srt[0]),
    .sorted1    (srt[1]),
    .sorted2    (srt[2]),
    .sorted3    (srt[3]),
    .sorted4    (srt[4]),
    .sorted5    (srt[5]),
    .sorted6    (srt[6]),
    .sorted7    (srt[7]),
    .sorted8    (srt[8]),
    .sorted9    (srt[9]),
    .nz_count   (nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask

  function automatic logic [18:0] mk(int hi, int s, int f);
    return {6'(hi), 5'(s), 8'(f)};
  endfunction

  function automatic bit less(logic [18:0] a, logic [18:0] b);
    if (a[7:0] != b[7:0]) return a[7:0] < b[7:0];
    return a[12:8] < b[12:8];
  endfunction

  // Stable selection sort: first minimum wins, so equal keys keep input order.
  task automatic model();
    logic [18:0] q[$];
    q = {};
    exp_nz = 0;
    for (int i = 0; i < 10; i++) begin
      q.push_back(din[i]);
      if (din[i][7:0] != 0) exp_nz++;
    end
    for (int k = 0; k < 10; k++) begin
      int m = 0;
      for (int j = 1; j < q.size(); j++) begin
        if (less(q[j], q[m])) m = j;
      end
      exp_s[k] = q[m];
      q.delete(m);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && armed && out_valid) begin
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("sorted%0d", k), 32'(srt[k]), 32'(exp_s[k]));
      end
      chk("nz_count", 32'(nz), 32'(exp_nz));
    end
  end

  task automatic chk_syms(input string n, input int s [10]);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_sym%0d", n, k), 32'(srt[k][12:8]), 32'(s[k]));
    end
  endtask

  task automatic send(input bit rdy);
    model();
    armed     = 1'b1;
    out_ready = rdy;
    req       = 1'b1;
    @(posedge clk); #1;
    chk("ack_hi", 32'(ack), 1);
    req = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) chk("ack_pulse", 32'(ack), 0);
    end while (!out_valid && lat < 40);
    chk("latency", lat, 10);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("accept", 32'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    total     = 0;
    bad       = 0;
    armed     = 1'b0;
    rst_n     = 1'b0;
    req       = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) din[i] = '0;
    #12;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_nz", 32'(nz), 0);
    chk("rst_sorted0", 32'(srt[0]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: mixed frequencies with zeros
    for (int i = 0; i < 10; i++) din[i] = mk(0, i, t1_in[i]);
    send(1'b0);
    chk_syms("t1", t1_syms);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t1_freq%0d", k), 32'(srt[k][7:0]), 32'(t1_freq[k]));
    end
    chk("t1_nz", 32'(nz), 7);
    accept();

    // T2: all equal; ready already high when valid rises
    for (int i = 0; i < 10; i++) din[i] = mk(0, i, 8);
    send(1'b1);
    chk_syms("t2", id_syms);
    chk("t2_nz", 32'(nz), 10);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t2_early_ready", 32'(out_valid), 0);

    // T3: descending 255..246, captured back-to-back
    for (int i = 0; i < 10; i++) din[i] = mk(0, i, 255 - i);
    send(1'b0);
    chk_syms("t3", rev_syms);
    chk("t3_first", 32'(srt[0][7:0]), 246);
    chk("t3_last", 32'(srt[9][7:0]), 255);
    accept();

    // T4: backpressure with a stray req mid-sort
    for (int i = 0; i < 10; i++) din[i] = mk(0, i, (i * 37) % 11);
    model();
    armed = 1'b1;
    req   = 1'b1;
    @(posedge clk); #1;
    chk("t4_ack", 32'(ack), 1);
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    req  = 1'b1;
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ack) acks++;
      if (c == 2) req = 1'b0;
    end
    chk("t4_no_second_ack", acks, 0);
    chk("t4_hold_valid", 32'(out_valid), 1);
    accept();
    for (int i = 0; i < 10; i++) din[i] = mk(1, 9 - i, i * 3);
    send(1'b0);
    accept();

    // T5: async reset during sorting
    for (int i = 0; i < 10; i++) din[i] = mk(0, i, 200 - i * 5);
    model();
    armed = 1'b1;
    req   = 1'b1;
    @(posedge clk); #1;
    chk("t5_ack", 32'(ack), 1);
    req = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ack", 32'(ack), 0);
    chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_sorted0", 32'(srt[0]), 0);
    chk("t5_rst_nz", 32'(nz), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) din[i] = mk(0, i, t1_in[9 - i]);
    send(1'b0);
    accept();

    // T6: upper bits travel with entries; duplicate symbols
    for (int i = 0; i < 10; i++) din[i] = mk(i + 33, i % 5, t6_freq[i]);
    send(1'b0);
    chk("t6_hi0", 32'(srt[0][18:13]), 37);
    chk("t6_hi1", 32'(srt[1][18:13]), 42);
    chk("t6_nz", 32'(nz), 8);
    accept();

    // T7: all zero frequencies
    for (int i = 0; i < 10; i++) din[i] = mk(0, i, 0);
    send(1'b0);
    chk_syms("t7", id_syms);
    chk("t7_nz", 32'(nz), 0);
    accept();

    armed = 1'b0;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
